// File: rtl/pixel_word_packer_if.sv
// Word-stream bus of the pixel packer: narrow words in, packed words out,
// plus FIFO level and error reporting.
interface pixel_word_packer_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned RATIO = 6,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned OUT_W  = IN_W * RATIO;
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  logic              din_vld;
  logic [IN_W-1:0]   din;
  logic              sof;
  logic              din_rdy;
  logic              dout_vld;
  logic [OUT_W-1:0]  dout;
  logic              dout_rdy;
  logic [FILL_W-1:0] fill_lvl;
  logic              ovf;
  logic              partial_drop;

  // Producer / consumer side (SDRAM FIFO reader and LCD fetch).
  modport master (
    output din_vld, din, sof, dout_rdy,
    input  din_rdy, dout_vld, dout, fill_lvl, ovf, partial_drop
  );

  // Packer side.
  modport slave (
    input  din_vld, din, sof, dout_rdy,
    output din_rdy, dout_vld, dout, fill_lvl, ovf, partial_drop
  );
endinterface

// File: rtl/pixel_word_packer.sv
// Packs RATIO consecutive IN_W-bit words into one wide word and buffers the
// result in a small first-word-fall-through FIFO with valid/ready output.
module pixel_word_packer #(
  parameter int unsigned IN_W      = 16,
  parameter int unsigned RATIO     = 6,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  pixel_word_packer_if.slave bus
);
  localparam int unsigned OUT_W  = IN_W * RATIO;
  localparam int unsigned CNT_W  = $clog2(RATIO);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);
  localparam int unsigned OFF_W  = $clog2(OUT_W);

  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(RATIO - 1);
  localparam logic [FILL_W-1:0] FULL_LVL  = FILL_W'(DEPTH);

  logic [CNT_W-1:0]  cnt, cnt_nxt, slot;
  logic [OUT_W-1:0]  asm_q, asm_nxt, packed_word;
  logic [OUT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
  logic [FILL_W-1:0] fill, fill_nxt;
  logic [OFF_W-1:0]  off;
  logic              vld_q, ovf_q, ovf_nxt, pd_q, pd_nxt;
  logic              last, full, rdy, acc, push, pop;

  // Handshake decode; a same-cycle pop does not free room for a completion.
  always_comb begin
    slot = bus.sof ? '0 : cnt;
    last = (slot == LAST_SLOT);
    full = (fill == FULL_LVL);
    rdy  = ~(last & full);
    acc  = bus.din_vld & rdy;
    push = acc & last;
    pop  = vld_q & bus.dout_rdy;
  end

  // Next-state logic for assembly, pointers, level and status flags.
  always_comb begin
    cnt_nxt    = cnt;
    asm_nxt    = asm_q;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    fill_nxt   = fill;
    ovf_nxt    = ovf_q | (bus.din_vld & ~rdy);
    pd_nxt     = bus.sof & (cnt != '0);

    if (MSB_FIRST != 0) begin
      off = OFF_W'((RATIO - 1 - 32'(slot)) * IN_W);
    end else begin
      off = OFF_W'(32'(slot) * IN_W);
    end
    // sof restarts from an empty word, dropping whatever was assembled.
    packed_word = bus.sof ? '0 : asm_q;
    packed_word[off +: IN_W] = bus.din;

    if (bus.sof) begin
      cnt_nxt = '0;
      asm_nxt = '0;
    end

    if (acc) begin
      if (last) begin
        cnt_nxt    = '0;
        asm_nxt    = '0;
        wr_ptr_nxt = wr_ptr + PTR_W'(1);
      end else begin
        cnt_nxt = slot + CNT_W'(1);
        asm_nxt = packed_word;
      end
    end

    if (pop) begin
      rd_ptr_nxt = rd_ptr + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   fill_nxt = fill + FILL_W'(1);
      2'b01:   fill_nxt = fill - FILL_W'(1);
      default: fill_nxt = fill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      asm_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
      pd_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      cnt    <= cnt_nxt;
      asm_q  <= asm_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      fill   <= fill_nxt;
      vld_q  <= (fill_nxt != '0);
      ovf_q  <= ovf_nxt;
      pd_q   <= pd_nxt;
      if (push) begin
        mem[wr_ptr] <= packed_word;
      end
    end
  end

  assign bus.din_rdy      = rdy;
  assign bus.dout_vld     = vld_q;
  assign bus.dout         = mem[rd_ptr];
  assign bus.fill_lvl     = fill;
  assign bus.ovf          = ovf_q;
  assign bus.partial_drop = pd_q;

endmodule

// File: tb/tb_pixel_word_packer.sv
// Bench for pixel_word_packer: MSB-first and LSB-first instances share one
// stimulus stream; directed vector table, corner sequences, random traffic.
module tb_pixel_word_packer;
  localparam int unsigned IN_W  = 16;
  localparam int unsigned RATIO = 6;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned OUT_W = IN_W * RATIO;

  logic            clk = 1'b0;
  logic            rst, din_vld, sof, dout_rdy;
  logic [IN_W-1:0] din;

  int checks = 0;
  int errors = 0;

  pixel_word_packer_if #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH)) bus_m ();
  pixel_word_packer_if #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH)) bus_l ();

  assign bus_m.din_vld  = din_vld;
  assign bus_m.din      = din;
  assign bus_m.sof      = sof;
  assign bus_m.dout_rdy = dout_rdy;
  assign bus_l.din_vld  = din_vld;
  assign bus_l.din      = din;
  assign bus_l.sof      = sof;
  assign bus_l.dout_rdy = dout_rdy;

  pixel_word_packer #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .bus(bus_m)
  );
  pixel_word_packer #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .bus(bus_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          r, v, s, dr;
    logic [15:0] d;
    bit          e_vld;
    logic [2:0]  e_fill;
    bit          e_pd;
    logic [95:0] e_dm, e_dl;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, input bit v, input logic [15:0] d, input bit s,
                              input bit dr, input bit ev, input logic [2:0] ef, input bit epd,
                              input logic [95:0] dm, input logic [95:0] dl);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.s = s; t.dr = dr;
    t.e_vld = ev; t.e_fill = ef; t.e_pd = epd; t.e_dm = dm; t.e_dl = dl;
    tbl.push_back(t);
  endfunction

  // ---------------- reference model ----------------
  logic [IN_W-1:0]  part[$];
  logic [OUT_W-1:0] q_m[$], q_l[$];
  bit               m_ovf = 1'b0;
  bit               m_pd  = 1'b0;

  // One clock: apply inputs, compare DUTs to the model, advance the model.
  task automatic step(input bit r, input bit v, input logic [15:0] d, input bit s, input bit dr);
    bit               exp_rdy, pd_n;
    int               cur;
    logic [OUT_W-1:0] vm, vl;
    rst = r; din_vld = v; din = d; sof = s; dout_rdy = dr;
    #1;
    cur     = s ? 0 : part.size();
    exp_rdy = !(cur == int'(RATIO) - 1 && q_m.size() == int'(DEPTH));
    chk("m.dout_vld", bus_m.dout_vld, q_m.size() != 0);
    chk("l.dout_vld", bus_l.dout_vld, q_l.size() != 0);
    chk("m.fill_lvl", bus_m.fill_lvl, q_m.size());
    chk("l.fill_lvl", bus_l.fill_lvl, q_l.size());
    chk("m.ovf", bus_m.ovf, m_ovf);
    chk("l.ovf", bus_l.ovf, m_ovf);
    chk("m.partial_drop", bus_m.partial_drop, m_pd);
    chk("l.partial_drop", bus_l.partial_drop, m_pd);
    if (q_m.size() != 0) begin
      chk("m.dout", bus_m.dout, q_m[0]);
      chk("l.dout", bus_l.dout, q_l[0]);
    end
    if (!r) begin
      chk("m.din_rdy", bus_m.din_rdy, exp_rdy);
      chk("l.din_rdy", bus_l.din_rdy, exp_rdy);
    end
    if (r) begin
      part.delete(); q_m.delete(); q_l.delete();
      m_ovf = 1'b0; m_pd = 1'b0;
    end else begin
      pd_n = s && part.size() != 0;
      if (dr && q_m.size() != 0) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
      if (s) part.delete();
      if (v) begin
        if (exp_rdy) begin
          part.push_back(d);
          if (part.size() == int'(RATIO)) begin
            vm = '0; vl = '0;
            for (int i = 0; i < int'(RATIO); i++) begin
              vm = {vm[OUT_W-IN_W-1:0], part[i]};
              vl[i*IN_W +: IN_W] = part[i];
            end
            q_m.push_back(vm);
            q_l.push_back(vl);
            part.delete();
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_pd = pd_n;
    end
    @(negedge clk);
  endtask

  logic [15:0] w;

  initial begin
    rst = 1'b1; din_vld = 1'b0; din = '0; sof = 1'b0; dout_rdy = 1'b0;

    // Basic packing, sof realignment, sof without data.
    add(1, 0, 16'h0000, 0, 0, 0, 0, 0, '0, '0);
    for (int i = 1; i <= 5; i++) begin
      w = 16'(i * 16'h1111);
      add(0, 1, w, 0, 1, 0, 0, 0, '0, '0);
    end
    add(0, 1, 16'h6666, 0, 1, 1, 1, 0, 96'h111122223333444455556666, 96'h666655554444333322221111);
    add(0, 0, 16'h0000, 0, 1, 0, 0, 0, '0, '0);
    add(0, 1, 16'h0001, 0, 1, 0, 0, 0, '0, '0);
    add(0, 1, 16'h0002, 0, 1, 0, 0, 0, '0, '0);
    add(0, 1, 16'h0003, 0, 1, 0, 0, 0, '0, '0);
    add(0, 1, 16'hAAAA, 1, 1, 0, 0, 1, '0, '0);
    for (int i = 11; i <= 14; i++) begin
      w = 16'(i);
      add(0, 1, w, 0, 1, 0, 0, 0, '0, '0);
    end
    add(0, 1, 16'h000F, 0, 1, 1, 1, 0, 96'hAAAA000B000C000D000E000F, 96'h000F000E000D000C000BAAAA);
    add(0, 0, 16'h0000, 0, 1, 0, 0, 0, '0, '0);
    add(0, 1, 16'h0021, 0, 1, 0, 0, 0, '0, '0);
    add(0, 1, 16'h0022, 0, 1, 0, 0, 0, '0, '0);
    add(0, 0, 16'h0000, 1, 1, 0, 0, 1, '0, '0);
    add(0, 0, 16'h0000, 1, 1, 0, 0, 0, '0, '0);
    for (int i = 1; i <= 5; i++) begin
      w = 16'(16'h0030 + i);
      add(0, 1, w, 0, 1, 0, 0, 0, '0, '0);
    end
    add(0, 1, 16'h0036, 0, 1, 1, 1, 0, 96'h003100320033003400350036, 96'h003600350034003300320031);
    add(0, 0, 16'h0000, 0, 1, 0, 0, 0, '0, '0);
    add(1, 0, 16'h0000, 0, 0, 0, 0, 0, '0, '0);

    @(negedge clk);
    for (int k = 0; k < tbl.size(); k++) begin
      rst = tbl[k].r; din_vld = tbl[k].v; din = tbl[k].d; sof = tbl[k].s; dout_rdy = tbl[k].dr;
      #1;
      if (!tbl[k].r) begin
        chk("tbl.m.din_rdy", bus_m.din_rdy, 1'b1);
        chk("tbl.l.din_rdy", bus_l.din_rdy, 1'b1);
      end
      @(negedge clk);
      chk("tbl.m.dout_vld", bus_m.dout_vld, tbl[k].e_vld);
      chk("tbl.m.fill_lvl", bus_m.fill_lvl, tbl[k].e_fill);
      chk("tbl.m.partial_drop", bus_m.partial_drop, tbl[k].e_pd);
      chk("tbl.l.partial_drop", bus_l.partial_drop, tbl[k].e_pd);
      chk("tbl.m.ovf", bus_m.ovf, 1'b0);
      if (tbl[k].e_vld || tbl[k].r) begin
        chk("tbl.m.dout", bus_m.dout, tbl[k].e_dm);
        chk("tbl.l.dout", bus_l.dout, tbl[k].e_dl);
      end
    end

    // Backpressure: 30 words with the consumer stalled.
    for (int i = 1; i <= 30; i++) step(0, 1, 16'(i), 0, 0);
    chk("bp.fill_lvl", bus_m.fill_lvl, 3'd4);
    chk("bp.ovf", bus_m.ovf, 1'b1);
    for (int i = 0; i < 6; i++) step(0, 0, 16'h0, 0, 1);
    chk("bp.drained", bus_m.fill_lvl, 3'd0);
    chk("bp.ovf_sticky", bus_m.ovf, 1'b1);

    // Reset with buffered and partial data present.
    step(0, 1, 16'h0777, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 16'(16'h0800 + i), 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 16'(16'h0900 + i), 0, 0);
    chk("rst.pre_fill", bus_m.fill_lvl, 3'd3);
    step(1, 1, 16'h5555, 1, 1);
    chk("rst.fill_lvl", bus_m.fill_lvl, 3'd0);
    chk("rst.dout_vld", bus_m.dout_vld, 1'b0);
    chk("rst.ovf", bus_m.ovf, 1'b0);
    chk("rst.partial_drop", bus_m.partial_drop, 1'b0);
    for (int i = 1; i <= 6; i++) step(0, 1, 16'(i * 16'h0101), 0, 0);
    chk("rst.clean_m", bus_m.dout, 96'h010102020303040405050606);
    chk("rst.clean_l", bus_l.dout, 96'h060605050404030302020101);
    step(0, 0, 16'h0, 0, 1);

    // Completion and pop on the same edge at fill_lvl=2, then wrap traffic.
    for (int i = 0; i < 17; i++) step(0, 1, 16'(16'h0A00 + i), 0, 0);
    chk("pp.pre_fill", bus_m.fill_lvl, 3'd2);
    step(0, 1, 16'h0A11, 0, 1);
    chk("pp.fill_lvl", bus_m.fill_lvl, 3'd2);
    for (int i = 0; i < int'(3 * DEPTH * RATIO); i++)
      step(0, 1, 16'(16'h0B00 + i), 0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 8; i++) step(0, 0, 16'h0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 9) < 7, 16'($urandom),
           $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
